// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   hz_state_e    : sequencer state (normal flow / multi-cycle vector op)
//   OPTYPE_SCALAR : ID/EX op type encoding for a scalar instruction
//   num_chunks()  : cycles a vector op needs in EX (ceil(v / lanes))
package pipe_pkg;

  typedef enum logic {
    HZ_RUN = 1'b0,
    HZ_VEC = 1'b1
  } hz_state_e;

  localparam logic [1:0] OPTYPE_SCALAR = 2'b00;

  function automatic int num_chunks(input int v, input int lanes);
    return (v + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit.
//   master : pipeline side, drives decode/EX/MEM status, consumes controls
//   slave  : hazard unit side
// Parameters: AW register address width, LIW chunk index width.
// With HAZARD_PERF_CNT_EN defined, adds stall_cnt_o / flush_cnt_o.
interface pipe_hazard_unit_if #(
  parameter int AW  = 4,
  parameter int LIW = 3
);
  // Decode stage
  logic          id_valid_i;
  logic [AW-1:0] id_A1_i;
  logic [AW-1:0] id_A2_i;
  logic          id_use1_i;
  logic          id_use2_i;
  logic          id_vec_i;
  // ID/EX stage
  logic          ex_valid_i;
  logic [AW-1:0] ex_A3_i;
  logic          ex_RegFile_WE_i;
  logic [1:0]    ex_OpType_i;
  // EX/MEM stage
  logic          mem_valid_i;
  logic [AW-1:0] mem_A3_i;
  logic          mem_RegFile_WE_i;
  logic          mem_vec_i;
  logic          branch_taken_i;
  // Controls
  logic           pc_enable_o;
  logic           if_id_enable_o;
  logic           if_id_flush_o;
  logic           id_ex_enable_o;
  logic           id_ex_bubble_o;
  logic           ex_mem_bubble_o;
  logic [LIW-1:0] lane_idx_o;
  logic           vec_busy_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]    stall_cnt_o;
  logic [31:0]    flush_cnt_o;
`endif

`ifdef HAZARD_PERF_CNT_EN
  modport master (
    output id_valid_i, id_A1_i, id_A2_i, id_use1_i, id_use2_i, id_vec_i,
           ex_valid_i, ex_A3_i, ex_RegFile_WE_i, ex_OpType_i,
           mem_valid_i, mem_A3_i, mem_RegFile_WE_i, mem_vec_i, branch_taken_i,
    input  pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_enable_o,
           id_ex_bubble_o, ex_mem_bubble_o, lane_idx_o, vec_busy_o,
           stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  id_valid_i, id_A1_i, id_A2_i, id_use1_i, id_use2_i, id_vec_i,
           ex_valid_i, ex_A3_i, ex_RegFile_WE_i, ex_OpType_i,
           mem_valid_i, mem_A3_i, mem_RegFile_WE_i, mem_vec_i, branch_taken_i,
    output pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_enable_o,
           id_ex_bubble_o, ex_mem_bubble_o, lane_idx_o, vec_busy_o,
           stall_cnt_o, flush_cnt_o
  );
`else
  modport master (
    output id_valid_i, id_A1_i, id_A2_i, id_use1_i, id_use2_i, id_vec_i,
           ex_valid_i, ex_A3_i, ex_RegFile_WE_i, ex_OpType_i,
           mem_valid_i, mem_A3_i, mem_RegFile_WE_i, mem_vec_i, branch_taken_i,
    input  pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_enable_o,
           id_ex_bubble_o, ex_mem_bubble_o, lane_idx_o, vec_busy_o
  );
  modport slave (
    input  id_valid_i, id_A1_i, id_A2_i, id_use1_i, id_use2_i, id_vec_i,
           ex_valid_i, ex_A3_i, ex_RegFile_WE_i, ex_OpType_i,
           mem_valid_i, mem_A3_i, mem_RegFile_WE_i, mem_vec_i, branch_taken_i,
    output pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_enable_o,
           id_ex_bubble_o, ex_mem_bubble_o, lane_idx_o, vec_busy_o
  );
`endif

endinterface

// File: rtl/pipe_hazard_unit_hazard_cmp.sv
// Combinational RAW comparator for one source operand.
//   a            : source register address from decode
//   id_vec       : source reads the vector file
//   ex_* / mem_* : in-flight writers in ID/EX and EX/MEM
//   hit          : some in-flight writer targets this register in the same file
module hazard_cmp #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] a,
  input  logic          id_vec,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_a3,
  input  logic          ex_we,
  input  logic          ex_vec,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_a3,
  input  logic          mem_we,
  input  logic          mem_vec,
  output logic          hit
);

  // Register files are separate, so an address only collides within one file.
  assign hit = (ex_valid  & ex_we  & (ex_a3  == a) & (ex_vec  == id_vec)) |
               (mem_valid & mem_we & (mem_a3 == a) & (mem_vec == id_vec));

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard / vector sequencing control.
//   CLK, RST : clock, synchronous active-high reset
//   hz       : pipe_hazard_unit_if.slave (decode/EX/MEM status in,
//              stall enables, bubbles, flush, chunk index out)
// Parameters: V elements per vector, LANES elements per EX cycle, AW address width.
// Optional HAZARD_PERF_CNT_EN: saturating stall / flush cycle counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_unit_if.slave hz
);

  localparam int CHUNKS = num_chunks(V, LANES);
  localparam int LIW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam bit MULTI  = (CHUNKS > 1);
  localparam logic [LIW-1:0] LAST = LIW'(CHUNKS - 1);

  hz_state_e      state, state_nx;
  logic [LIW-1:0] chunk_cnt, chunk_nx;

  logic hit1, hit2, raw, ex_vec, vec_start;

  assign ex_vec = (hz.ex_OpType_i != OPTYPE_SCALAR);

  hazard_cmp #(.AW(AW)) u_cmp1 (
    .a(hz.id_A1_i), .id_vec(hz.id_vec_i),
    .ex_valid(hz.ex_valid_i), .ex_a3(hz.ex_A3_i), .ex_we(hz.ex_RegFile_WE_i),
    .ex_vec(ex_vec),
    .mem_valid(hz.mem_valid_i), .mem_a3(hz.mem_A3_i), .mem_we(hz.mem_RegFile_WE_i),
    .mem_vec(hz.mem_vec_i), .hit(hit1)
  );

  hazard_cmp #(.AW(AW)) u_cmp2 (
    .a(hz.id_A2_i), .id_vec(hz.id_vec_i),
    .ex_valid(hz.ex_valid_i), .ex_a3(hz.ex_A3_i), .ex_we(hz.ex_RegFile_WE_i),
    .ex_vec(ex_vec),
    .mem_valid(hz.mem_valid_i), .mem_a3(hz.mem_A3_i), .mem_we(hz.mem_RegFile_WE_i),
    .mem_vec(hz.mem_vec_i), .hit(hit2)
  );

  assign raw       = hz.id_valid_i & ((hz.id_use1_i & hit1) | (hz.id_use2_i & hit2));
  assign vec_start = MULTI & hz.ex_valid_i & ex_vec;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    hz.pc_enable_o     = 1'b1;
    hz.if_id_enable_o  = 1'b1;
    hz.if_id_flush_o   = 1'b0;
    hz.id_ex_enable_o  = 1'b1;
    hz.id_ex_bubble_o  = 1'b0;
    hz.ex_mem_bubble_o = 1'b0;
    hz.lane_idx_o      = '0;
    hz.vec_busy_o      = 1'b0;
    state_nx           = state;
    chunk_nx           = chunk_cnt;

    // While RST is high the pipeline registers are being cleared anyway;
    // present the idle control word regardless of the stale state.
    if (!RST) begin
      unique case (state)
        HZ_RUN: begin
          if (hz.branch_taken_i) begin
            // Younger instruction in decode is discarded, so its RAW is moot.
            hz.if_id_flush_o  = 1'b1;
            hz.id_ex_bubble_o = 1'b1;
          end else if (vec_start) begin
            hz.vec_busy_o      = 1'b1;
            hz.pc_enable_o     = 1'b0;
            hz.if_id_enable_o  = 1'b0;
            hz.id_ex_enable_o  = 1'b0;
            hz.ex_mem_bubble_o = 1'b1;
            state_nx           = HZ_VEC;
            chunk_nx           = LIW'(1);
          end else if (raw) begin
            hz.pc_enable_o    = 1'b0;
            hz.if_id_enable_o = 1'b0;
            hz.id_ex_bubble_o = 1'b1;
          end
        end
        HZ_VEC: begin
          hz.lane_idx_o = chunk_cnt;
          hz.vec_busy_o = 1'b1;
          if (chunk_cnt != LAST) begin
            hz.pc_enable_o     = 1'b0;
            hz.if_id_enable_o  = 1'b0;
            hz.id_ex_enable_o  = 1'b0;
            hz.ex_mem_bubble_o = 1'b1;
            chunk_nx           = chunk_cnt + LIW'(1);
          end else begin
            // Final chunk: the op result reaches EX/MEM; decode may proceed
            // unless it depends on an in-flight writer.
            if (raw) begin
              hz.pc_enable_o    = 1'b0;
              hz.if_id_enable_o = 1'b0;
              hz.id_ex_bubble_o = 1'b1;
            end
            state_nx = HZ_RUN;
            chunk_nx = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HZ_RUN;
      chunk_cnt <= '0;
    end else begin
      state     <= state_nx;
      chunk_cnt <= chunk_nx;
    end
  end

  // A branch cannot resolve while EX is occupied by a multi-cycle vector op.
  always_ff @(posedge CLK) begin
    if (!RST && state == HZ_VEC) assert (!hz.branch_taken_i);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!hz.pc_enable_o && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (hz.if_id_flush_o && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_o = stall_cnt;
  assign hz.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit (V=20, LANES=4, CHUNKS=5).
// Expected control words are pushed to a scoreboard when inputs are driven and
// popped/compared at the falling edge of the same cycle.
module tb_pipe_hazard_unit;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  pipe_hazard_unit_if #(.AW(4), .LIW(3)) hz_if ();

  pipe_hazard_unit #(.V(20), .LANES(4), .AW(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hz_if.slave)
  );

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       flush;
    logic       idex;
    logic       bub;
    logic       exmb;
    logic [2:0] lane;
    logic       busy;
  } ctl_t;

  ctl_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic ctl_t mk(logic pc, logic ifid, logic flush, logic idex,
                              logic bub, logic exmb, int lane, logic busy);
    ctl_t c;
    c.pc = pc; c.ifid = ifid; c.flush = flush; c.idex = idex;
    c.bub = bub; c.exmb = exmb; c.lane = 3'(lane); c.busy = busy;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Push expectation, compare at negedge, then advance to just after the next posedge.
  task automatic cyc(input string tag, input ctl_t exp);
    ctl_t e;
    sb_q.push_back(exp);
    @(negedge CLK);
    e = sb_q.pop_front();
    check({tag, ".pc_enable"},     32'(hz_if.pc_enable_o),     32'(e.pc));
    check({tag, ".if_id_enable"},  32'(hz_if.if_id_enable_o),  32'(e.ifid));
    check({tag, ".if_id_flush"},   32'(hz_if.if_id_flush_o),   32'(e.flush));
    check({tag, ".id_ex_enable"},  32'(hz_if.id_ex_enable_o),  32'(e.idex));
    check({tag, ".id_ex_bubble"},  32'(hz_if.id_ex_bubble_o),  32'(e.bub));
    check({tag, ".ex_mem_bubble"}, 32'(hz_if.ex_mem_bubble_o), 32'(e.exmb));
    check({tag, ".lane_idx"},      32'(hz_if.lane_idx_o),      32'(e.lane));
    check({tag, ".vec_busy"},      32'(hz_if.vec_busy_o),      32'(e.busy));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    hz_if.id_valid_i = 0; hz_if.id_A1_i = 0; hz_if.id_A2_i = 0;
    hz_if.id_use1_i = 0; hz_if.id_use2_i = 0; hz_if.id_vec_i = 0;
    hz_if.ex_valid_i = 0; hz_if.ex_A3_i = 0; hz_if.ex_RegFile_WE_i = 0;
    hz_if.ex_OpType_i = 2'b00;
    hz_if.mem_valid_i = 0; hz_if.mem_A3_i = 0; hz_if.mem_RegFile_WE_i = 0;
    hz_if.mem_vec_i = 0; hz_if.branch_taken_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t run_w, raw_w, frz_w, br_w;
    run_w = mk(1, 1, 0, 1, 0, 0, 0, 0);
    raw_w = mk(0, 0, 0, 1, 1, 0, 0, 0);
    br_w  = mk(1, 1, 1, 1, 1, 0, 0, 0);

    idle_inputs();
    RST = 1;
    @(posedge CLK); #1;
    cyc("reset0", run_w);
    cyc("reset1", run_w);
    RST = 0;
    cyc("idle", run_w);

    // Vector op, interrupted by reset at chunk 3.
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd7; hz_if.ex_RegFile_WE_i = 1;
    hz_if.ex_OpType_i = 2'b01;
    for (int i = 0; i < 4; i++) cyc($sformatf("rstvec%0d", i), mk(0, 0, 0, 0, 0, 1, i, 1));
    RST = 1;
    idle_inputs();
    cyc("midvec_rst0", run_w);
    cyc("midvec_rst1", run_w);
    RST = 0;
    cyc("after_rst", run_w);

    // Scalar RAW against EX then MEM, then retired.
    hz_if.id_valid_i = 1; hz_if.id_A1_i = 4'd5; hz_if.id_use1_i = 1;
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd5; hz_if.ex_RegFile_WE_i = 1;
    cyc("raw_ex", raw_w);
    hz_if.ex_valid_i = 0;
    hz_if.mem_valid_i = 1; hz_if.mem_A3_i = 4'd5; hz_if.mem_RegFile_WE_i = 1;
    cyc("raw_mem", raw_w);
    hz_if.mem_valid_i = 0;
    cyc("raw_done", run_w);

    // Same address, different register file.
    hz_if.id_vec_i = 1;
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd5; hz_if.ex_RegFile_WE_i = 1;
    hz_if.ex_OpType_i = 2'b00;
    cyc("file_mismatch", run_w);

    // Full vector op: five chunks.
    idle_inputs();
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd2; hz_if.ex_RegFile_WE_i = 1;
    hz_if.ex_OpType_i = 2'b01;
    for (int i = 0; i < 4; i++) cyc($sformatf("vec%0d", i), mk(0, 0, 0, 0, 0, 1, i, 1));
    cyc("vec_last", mk(1, 1, 0, 1, 0, 0, 4, 1));
    idle_inputs();
    cyc("vec_after", run_w);

    // Branch taken overrides a simultaneous RAW.
    hz_if.id_valid_i = 1; hz_if.id_A1_i = 4'd3; hz_if.id_use1_i = 1;
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd3; hz_if.ex_RegFile_WE_i = 1;
    hz_if.branch_taken_i = 1;
    cyc("branch_raw", br_w);
    idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", hz_if.stall_cnt_o, 32'd6);
    check("flush_cnt", hz_if.flush_cnt_o, 32'd1);
`endif

    // Second operand against a vector writer in MEM.
    hz_if.id_valid_i = 1; hz_if.id_A2_i = 4'd9; hz_if.id_use2_i = 1; hz_if.id_vec_i = 1;
    hz_if.mem_valid_i = 1; hz_if.mem_A3_i = 4'd9; hz_if.mem_RegFile_WE_i = 1;
    hz_if.mem_vec_i = 1;
    cyc("raw_src2_vec", raw_w);
    hz_if.mem_RegFile_WE_i = 0;
    cyc("no_we", run_w);
    hz_if.mem_RegFile_WE_i = 1; hz_if.id_use2_i = 0;
    cyc("unused_src", run_w);

    // Vector op whose final chunk is consumed by the instruction in decode.
    idle_inputs();
    hz_if.ex_valid_i = 1; hz_if.ex_A3_i = 4'd6; hz_if.ex_RegFile_WE_i = 1;
    hz_if.ex_OpType_i = 2'b10;
    for (int i = 0; i < 4; i++) cyc($sformatf("vraw%0d", i), mk(0, 0, 0, 0, 0, 1, i, 1));
    hz_if.id_valid_i = 1; hz_if.id_A1_i = 4'd6; hz_if.id_use1_i = 1; hz_if.id_vec_i = 1;
    cyc("vraw_last", mk(0, 0, 0, 1, 1, 0, 4, 1));
    hz_if.ex_valid_i = 0;
    hz_if.mem_valid_i = 1; hz_if.mem_A3_i = 4'd6; hz_if.mem_RegFile_WE_i = 1;
    hz_if.mem_vec_i = 1;
    cyc("vraw_mem", raw_w);
    idle_inputs();
    cyc("final_idle", run_w);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
